asrv32_fetch_ctrl: RTL

//   Instruction-fetch sequencer that feeds the decoder. Issues one instruction-memory read at a time.

---
 rtl/asrv32_fetch_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/asrv32_fetch_ctrl.sv
// Instruction-fetch sequencer: one outstanding imem read, a small fall-through FIFO
// of {pc, inst} pairs toward the decoder, and a flush-and-restart on PC redirect.
//   state | meaning
//   IDLE  | FIFO full, no request; wait for a pop
//   ISSUE | decide whether to launch the next read
//   WAIT  | read outstanding at pc, response is kept
//   DRAIN | read outstanding on an abandoned address, response is dropped
module asrv32_fetch_ctrl #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_istb,
  output logic [31:0] o_iaddr,
  input  logic        i_iack,
  input  logic [31:0] i_idata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_inst_valid,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   iaddr, iaddr_nxt;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          space, push, pop;

  assign space = (count < DEPTH_C);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    iaddr_nxt = iaddr;
    push      = 1'b0;
    case (state)
      IDLE:  if (space) state_nxt = ISSUE;
      ISSUE: begin
        if (space) begin
          state_nxt = WAIT;
          iaddr_nxt = pc;
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (i_iack) begin
          push      = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = ISSUE;
        end
      end
      DRAIN: if (i_iack) state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
    // A live strobe must be held until its ack, so a redirect mid-read drains it.
    if (i_redirect) begin
      push      = 1'b0;
      pc_nxt    = i_redirect_pc & ~32'h3;
      iaddr_nxt = iaddr;
      if ((state == WAIT || state == DRAIN) && !i_iack) state_nxt = DRAIN;
      else state_nxt = ISSUE;
    end
  end

  assign pop = (count != '0) && !i_stall && !i_redirect;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= ISSUE;
      pc     <= PC_RESET;
      iaddr  <= PC_RESET;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      iaddr <= iaddr_nxt;
      if (i_redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= i_idata;
      fifo_pc[wr_ptr]   <= iaddr;
    end
  end

  assign o_istb       = (state == WAIT) || (state == DRAIN);
  assign o_iaddr      = iaddr;
  assign o_inst_valid = (count != '0);
  assign o_inst       = o_inst_valid ? fifo_inst[rd_ptr] : NOP;
  assign o_pc         = o_inst_valid ? fifo_pc[rd_ptr] : 32'h0;

endmodule
